stack_ctrl: RTL and testbench

Sequencer for the stack machine's operand stack. It accepts one stack instruction at a time over a valid/ready handshake and drives the stack-counter op (DES_2/DES_1/ADV_1/hold) to the `sc` block. It also drives the single-port stack register file and the ALU operand registers. It sits between instruction decode and the `sc`/stack-memory/ALU datapath, and adds optional overflow/underflow protection.

---
 rtl/stack_ctrl_pkg.sv | 41 ++++
 rtl/stack_ctrl_if.sv | 26 ++
 rtl/stack_depth.sv | 42 ++++
 rtl/stack_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_stack_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared types for the operand-stack sequencer.
//   stack_op_t : instruction codes carried on req_op (6 and 7 are illegal)
//   sc_op_t    : stack-counter commands driven to the sc block
//   state_t    : sequencer FSM states
//   op_legal() : true for the six defined instruction codes
package stack_ctrl_pkg;

   typedef enum logic [2:0] {
      S_PUSH  = 3'd0,
      S_POP   = 3'd1,
      S_DUP   = 3'd2,
      S_SWAP  = 3'd3,
      S_BINOP = 3'd4,
      S_DROP2 = 3'd5
   } stack_op_t;

   typedef enum logic [1:0] {
      SC_HOLD = 2'b00,
      ADV_1   = 2'b01,
      DES_1   = 2'b10,
      DES_2   = 2'b11
   } sc_op_t;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      RD_A,
      RD_B,
      WR_RES,
      WR_DUP,
      SW_WR1,
      SW_WR2
   } state_t;

   localparam logic [4:0] MAX_DEPTH = 5'd16;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= S_DROP2;
   endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: instruction request / completion bundle between decode
// (master) and stack_ctrl (slave).
//   req_valid, req_op, req_data : request from decode
//   req_ready                   : sequencer idle
//   done, err, pop_data         : completion pulse, reject flag, last POP value
interface stack_ctrl_if #(
   parameter int unsigned DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [DW-1:0] req_data;
   logic [DW-1:0] pop_data;
   logic          done;
   logic          err;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, pop_data, done, err
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, pop_data, done, err
   );
endinterface

// File: rtl/stack_depth.sv
// stack_depth: stack occupancy counter and bounds comparator.
//   clk, reset : clock, synchronous active-high reset
//   sc_op      : the command sent to sc; depth tracks it on the same edge
//   op         : instruction code being offered for accept
//   depth      : entries on the stack, 0..16
//   ok         : op fits the current depth (no overflow / underflow)
module stack_depth
   import stack_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  sc_op_t     sc_op,
   input  logic [2:0] op,
   output logic [4:0] depth,
   output logic       ok
);

   always_ff @(posedge clk) begin
      if (reset) begin
         depth <= '0;
      end else begin
         case (sc_op)
            ADV_1:   depth <= depth + 5'd1;
            DES_1:   depth <= depth - 5'd1;
            DES_2:   depth <= depth - 5'd2;
            default: depth <= depth;
         endcase
      end
   end

   always_comb begin
      ok = 1'b0;
      case (op)
         S_PUSH:                  ok = (depth < MAX_DEPTH);
         S_DUP:                   ok = (depth != '0) && (depth < MAX_DEPTH);
         S_POP:                   ok = (depth != '0);
         S_SWAP, S_BINOP, S_DROP2: ok = (depth >= 5'd2);
         default:                 ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: operand-stack sequencer. Accepts one instruction at a time,
// sequences reads/writes of the single-port stack RF and drives sc_op.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : stack_ctrl_if.slave (req_valid/ready/op/data, done, err, pop_data)
//   sc          : current stack counter (next free slot)
//   sc_op       : stack-counter command, non-hold only in an op's final cycle
//   mem_addr/we/wdata, mem_rdata : stack RF port (combinational read)
//   alu_a/alu_b : registered operands (old top / old second)
//   alu_result  : combinational ALU output
//   depth       : entries on the stack (0 when bounds checking is off)
// Build option: STACK_CTRL_BOUNDS_CHECK_EN adds the depth counter and
// rejects overflowing/underflowing ops with err.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   stack_ctrl_if.slave   bus,
   input  logic [3:0]    sc,
   output logic [1:0]    sc_op,
   output logic [3:0]    mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_result,
   output logic [4:0]    depth
);

   state_t        state;
   logic [2:0]    op_q;
   sc_op_t        sc_op_q;
   logic [3:0]    addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] pop_q;
   logic          done_q;
   logic          err_q;
   logic          bounds_ok;
   logic          reject;
   logic [3:0]    sc_m1;
   logic [3:0]    sc_m2;

   assign sc_m1 = sc - 4'd1;
   assign sc_m2 = sc - 4'd2;

`ifdef STACK_CTRL_BOUNDS_CHECK_EN
   stack_depth u_depth (
      .clk   (clk),
      .reset (reset),
      .sc_op (sc_op_q),
      .op    (bus.req_op),
      .depth (depth),
      .ok    (bounds_ok)
   );
`else
   assign depth     = '0;
   assign bounds_ok = 1'b1;
`endif

   assign reject        = !op_legal(bus.req_op) || !bounds_ok;
   assign bus.req_ready = (state == IDLE);

   // Outputs are registered on the edge entering the state that uses them;
   // sc is stable for the whole op, so addresses computed at the previous
   // edge are still correct.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= '0;
         sc_op_q <= SC_HOLD;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         pop_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q <= bus.req_op;
                  if (reject) begin
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     case (bus.req_op)
                        S_PUSH: begin
                           state   <= EXEC;
                           addr_q  <= sc;
                           we_q    <= 1'b1;
                           wdata_q <= bus.req_data;
                           sc_op_q <= ADV_1;
                        end
                        S_POP: begin
                           state   <= EXEC;
                           addr_q  <= sc_m1;
                           sc_op_q <= DES_1;
                        end
                        S_DROP2: begin
                           state   <= EXEC;
                           sc_op_q <= DES_2;
                        end
                        default: begin
                           state  <= RD_A;
                           addr_q <= sc_m1;
                        end
                     endcase
                  end
               end
            end
            EXEC: begin
               if (op_q == S_POP) pop_q <= mem_rdata;
               state   <= IDLE;
               we_q    <= 1'b0;
               sc_op_q <= SC_HOLD;
               done_q  <= 1'b1;
            end
            RD_A: begin
               a_q <= mem_rdata;
               if (op_q == S_DUP) begin
                  state   <= WR_DUP;
                  addr_q  <= sc;
                  we_q    <= 1'b1;
                  wdata_q <= mem_rdata;
                  sc_op_q <= ADV_1;
               end else begin
                  state  <= RD_B;
                  addr_q <= sc_m2;
               end
            end
            RD_B: begin
               b_q    <= mem_rdata;
               addr_q <= sc_m2;
               we_q   <= 1'b1;
               if (op_q == S_BINOP) begin
                  state   <= WR_RES;
                  sc_op_q <= DES_1;
               end else begin
                  state   <= SW_WR1;
                  wdata_q <= a_q;
               end
            end
            SW_WR1: begin
               state   <= SW_WR2;
               addr_q  <= sc_m1;
               wdata_q <= b_q;
            end
            WR_RES, WR_DUP, SW_WR2: begin
               state   <= IDLE;
               we_q    <= 1'b0;
               sc_op_q <= SC_HOLD;
               done_q  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // alu_b only lands on the RD_B->WR_RES edge, so the result is written
   // straight from the ALU rather than through the write-data register.
   assign mem_wdata    = (state == WR_RES) ? alu_result : wdata_q;
   assign sc_op        = sc_op_q;
   assign mem_addr     = addr_q;
   assign mem_we       = we_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign bus.pop_data = pop_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: self-checking bench for stack_ctrl. Provides a stand-in sc
// counter, a 16-entry stack RF and an adding ALU; checks a directed table,
// hand-written corner sequences and random ops against a stack-level model.
module tb_stack_ctrl;
   import stack_ctrl_pkg::*;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    sc;
   logic [1:0]    sc_op;
   logic [3:0]    mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_result;
   logic [4:0]    depth;
   logic [7:0]    rf [16] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7,
                              8'hE8, 8'hE9, 8'hEA, 8'hEB, 8'hEC, 8'hED, 8'hEE, 8'hEF};

   stack_ctrl_if #(.DW(DW)) bus ();

   stack_ctrl #(.DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .sc         (sc),
      .sc_op      (sc_op),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .depth      (depth)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) sc <= 4'd0;
      else if (sc_op == ADV_1) sc <= sc + 4'd1;
      else if (sc_op == DES_1) sc <= sc - 4'd1;
      else if (sc_op == DES_2) sc <= sc - 4'd2;
   end

   always @(posedge clk) if (mem_we) rf[mem_addr] <= mem_wdata;
   assign mem_rdata  = rf[mem_addr];
   assign alu_result = alu_a + alu_b;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---- stack-level reference model ----
   logic [7:0] rf_m [16];
   logic [3:0] sc_m;
   int         depth_m;
   logic [7:0] pop_m;

   task automatic model_reset();
      sc_m    = 4'd0;
      depth_m = 0;
      pop_m   = 8'h00;
   endtask

   task automatic model_op(input logic [2:0] op, input logic [7:0] d,
                           output logic e, output int lat, output int wr, output int nsc);
      logic [3:0] t1;
      logic [3:0] t2;
      logic [7:0] tmp;
      t1 = sc_m - 4'd1;
      t2 = sc_m - 4'd2;
      e = 1'b0; lat = 0; wr = 0; nsc = 0;
      if (op > 3'd5) begin
         e = 1'b1;
         return;
      end
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
      if (op == S_PUSH)     e = (depth_m > 15);
      else if (op == S_POP) e = (depth_m < 1);
      else if (op == S_DUP) e = (depth_m < 1) || (depth_m > 15);
      else                  e = (depth_m < 2);
      if (e) return;
`endif
      case (op)
         S_PUSH:  begin rf_m[sc_m] = d; sc_m = sc_m + 4'd1; depth_m++; lat = 1; wr = 1; nsc = 1; end
         S_POP:   begin pop_m = rf_m[t1]; sc_m = t1; depth_m--; lat = 1; nsc = 1; end
         S_DUP:   begin rf_m[sc_m] = rf_m[t1]; sc_m = sc_m + 4'd1; depth_m++; lat = 2; wr = 1; nsc = 1; end
         S_SWAP:  begin tmp = rf_m[t1]; rf_m[t1] = rf_m[t2]; rf_m[t2] = tmp; lat = 4; wr = 2; end
         S_BINOP: begin rf_m[t2] = rf_m[t1] + rf_m[t2]; sc_m = t1; depth_m--; lat = 3; wr = 1; nsc = 1; end
         default: begin sc_m = t2; depth_m -= 2; lat = 1; nsc = 1; end
      endcase
   endtask

   function automatic int rf_mism();
      int c = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== rf_m[i]) c++;
      return c;
   endfunction

   // Issue one op; lat = cycles after the accept cycle before done is seen.
   task automatic run_op(input logic [2:0] op, input logic [7:0] d,
                         output int lat, output logic e, output int wr, output int nsc);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = d;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'($urandom_range(0, 7));
      bus.req_data  = 8'($urandom);
      lat = 0; wr = 0; nsc = 0;
      while (!bus.done && lat < 12) begin
         if (mem_we) wr++;
         if (sc_op != SC_HOLD) nsc++;
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
      if (mem_we) wr++;
      if (sc_op != SC_HOLD) nsc++;
      e = bus.err;
   endtask

   task automatic check_op(input logic [2:0] op, input logic [7:0] d);
      logic e_x, e_a;
      int   lat_x, wr_x, nsc_x, lat_a, wr_a, nsc_a, d_x;
      model_op(op, d, e_x, lat_x, wr_x, nsc_x);
      run_op(op, d, lat_a, e_a, wr_a, nsc_a);
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
      d_x = depth_m;
`else
      d_x = 0;
`endif
      chk($sformatf("lat op%0d", op), lat_a, lat_x);
      chk($sformatf("err op%0d", op), e_a, e_x);
      chk($sformatf("writes op%0d", op), wr_a, wr_x);
      chk($sformatf("sc_ops op%0d", op), nsc_a, nsc_x);
      chk($sformatf("sc op%0d", op), sc, sc_m);
      chk($sformatf("depth op%0d", op), depth, d_x);
      chk($sformatf("pop_data op%0d", op), bus.pop_data, pop_m);
      chk($sformatf("rf op%0d", op), rf_mism(), 0);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      logic       exp_err;
      int         exp_lat;
      logic [3:0] exp_sc;
      logic [7:0] exp_pop;
   } vec_t;

   vec_t vecs [18];

   initial begin
      logic       e;
      int         lat, wr, nsc, weacc, dnacc;

      vecs[0]  = '{S_PUSH,  8'h11, 1'b0, 1, 4'd1, 8'h00};
      vecs[1]  = '{S_PUSH,  8'h22, 1'b0, 1, 4'd2, 8'h00};
      vecs[2]  = '{S_BINOP, 8'h00, 1'b0, 3, 4'd1, 8'h00};
      vecs[3]  = '{S_POP,   8'h00, 1'b0, 1, 4'd0, 8'h33};
      vecs[4]  = '{S_PUSH,  8'h0A, 1'b0, 1, 4'd1, 8'h33};
      vecs[5]  = '{S_PUSH,  8'h0B, 1'b0, 1, 4'd2, 8'h33};
      vecs[6]  = '{S_SWAP,  8'h00, 1'b0, 4, 4'd2, 8'h33};
      vecs[7]  = '{S_POP,   8'h00, 1'b0, 1, 4'd1, 8'h0A};
      vecs[8]  = '{S_POP,   8'h00, 1'b0, 1, 4'd0, 8'h0B};
      vecs[9]  = '{3'd7,    8'h00, 1'b1, 0, 4'd0, 8'h0B};
      vecs[10] = '{3'd6,    8'h00, 1'b1, 0, 4'd0, 8'h0B};
      vecs[11] = '{S_PUSH,  8'h05, 1'b0, 1, 4'd1, 8'h0B};
      vecs[12] = '{S_DUP,   8'h00, 1'b0, 2, 4'd2, 8'h0B};
      vecs[13] = '{S_POP,   8'h00, 1'b0, 1, 4'd1, 8'h05};
      vecs[14] = '{S_POP,   8'h00, 1'b0, 1, 4'd0, 8'h05};
      vecs[15] = '{S_PUSH,  8'h07, 1'b0, 1, 4'd1, 8'h05};
      vecs[16] = '{S_PUSH,  8'h09, 1'b0, 1, 4'd2, 8'h05};
      vecs[17] = '{S_DROP2, 8'h00, 1'b0, 1, 4'd0, 8'h05};

      rf_m = rf;
      model_reset();
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_data  = 8'h00;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst req_ready", bus.req_ready, 1'b1);
      chk("rst done", bus.done, 1'b0);
      chk("rst err", bus.err, 1'b0);
      chk("rst mem_we", mem_we, 1'b0);
      chk("rst sc_op", sc_op, SC_HOLD);
      chk("rst depth", depth, 5'd0);
      chk("rst alu_a", alu_a, 8'h00);
      chk("rst alu_b", alu_b, 8'h00);
      chk("rst pop_data", bus.pop_data, 8'h00);
      chk("rst mem_addr", mem_addr, 4'd0);
      chk("rst mem_wdata", mem_wdata, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // ---- directed table ----
      for (int i = 0; i < 18; i++) begin
         check_op(vecs[i].op, vecs[i].data);
         // re-run expectations against the table's own constants
         chk($sformatf("tbl%0d sc", i), sc, vecs[i].exp_sc);
         chk($sformatf("tbl%0d pop", i), bus.pop_data, vecs[i].exp_pop);
         chk($sformatf("tbl%0d err", i), bus.err, vecs[i].exp_err);
         if (vecs[i].op == S_BINOP) chk("binop rf0", rf[0], 8'h33);
         if (vecs[i].op == S_SWAP) chk("swap rf1", rf[1], 8'h0A);
      end
      @(posedge clk); #1;
      chk("done pulse width", bus.done, 1'b0);

      // ---- POP on empty stack ----
      check_op(S_POP, 8'h00);
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
      chk("empty pop err", bus.err, 1'b1);
      chk("empty pop sc", sc, 4'd0);
`endif

      // ---- reset during RD_B of a SWAP ----
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); reset = 1'b0;
      model_reset();
      check_op(S_PUSH, 8'h03);
      check_op(S_PUSH, 8'h04);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = S_SWAP; bus.req_data = 8'h00;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rdb addr", mem_addr, 4'd0);
      chk("rdb alu_a", alu_a, 8'h04);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort req_ready", bus.req_ready, 1'b1);
      chk("abort done", bus.done, 1'b0);
      @(negedge clk); reset = 1'b0;
      model_reset();
      weacc = 0; dnacc = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (mem_we) weacc++;
         if (bus.done) dnacc++;
      end
      chk("abort writes", weacc, 0);
      chk("abort late done", dnacc, 0);
      chk("abort sc", sc, 4'd0);
      chk("abort rf", rf_mism(), 0);

      // ---- fill to 16 then overflow ----
      for (int i = 0; i < 16; i++) check_op(S_PUSH, 8'(i + 8'h40));
      check_op(S_PUSH, 8'hFF);
`ifdef STACK_CTRL_BOUNDS_CHECK_EN
      chk("ovf err", bus.err, 1'b1);
      chk("ovf rf15", rf[15], 8'h4F);
      chk("ovf depth", depth, 5'd16);
`else
      chk("wrap err", bus.err, 1'b0);
      chk("wrap rf0", rf[0], 8'hFF);
      chk("wrap sc", sc, 4'd1);
`endif

      // ---- random ops against the model ----
      for (int i = 0; i < 200; i++) begin
         logic [2:0] rop;
         rop = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         check_op(rop, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
